// File: rtl/wdg_window_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : wdg_window_monitor_if
// Brief    : Heartbeat, enable and acknowledge inputs plus alarm status
//            outputs of the window watchdog monitor.
// Revision : 1.0 - initial release
// ============================================================================
interface wdg_window_monitor_if;
    logic       en;
    logic       pulse;
    logic       ack;
    logic       alarm;
    logic [1:0] cause;
    logic [7:0] beats;
    logic [1:0] st;

    modport master (output en, pulse, ack, input alarm, cause, beats, st);
    modport slave  (input en, pulse, ack, output alarm, cause, beats, st);
endinterface
`default_nettype wire

// File: rtl/wdg_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : wdg_window_monitor
// Brief    : Window watchdog. Measures the gap between heartbeat pulses and
//            raises a sticky alarm on early or missing pulses.
// Revision : 1.0 - initial release
// ============================================================================
module wdg_window_monitor #(
    parameter int TIMEOUT = 1000,
    parameter int EARLY   = 10,
    parameter int CNT_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    wdg_window_monitor_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ARM   = 2'b01,
        S_RUN   = 2'b10,
        S_ALARM = 2'b11
    } state_t;

    localparam logic [CNT_W-1:0] c_CNT_LAST    = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W:0]   c_EARLY       = (CNT_W + 1)'(EARLY);
    localparam bit               c_EARLY_ON    = (EARLY >= 2);
    localparam logic [1:0]       c_CAUSE_NONE  = 2'b00;
    localparam logic [1:0]       c_CAUSE_TMO   = 2'b01;
    localparam logic [1:0]       c_CAUSE_EARLY = 2'b10;

    state_t           r_st;
    logic [CNT_W-1:0] r_cnt;
    logic             r_alarm;
    logic [1:0]       r_cause;
    logic [7:0]       r_beats;

    state_t           w_st_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_alarm_nxt;
    logic [1:0]       w_cause_nxt;
    logic [7:0]       w_beats_nxt;

    logic [CNT_W:0]   w_gap;
    logic             w_early;
    logic             w_last;
    logic [7:0]       w_beats_inc;

    // One extra bit keeps cnt+1 from wrapping at the top of the counter range.
    assign w_gap       = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
    assign w_early     = c_EARLY_ON && (w_gap < c_EARLY);
    assign w_last      = (r_cnt == c_CNT_LAST);
    assign w_beats_inc = (r_beats == 8'hFF) ? 8'hFF : (r_beats + 8'd1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_st    <= S_IDLE;
            r_cnt   <= '0;
            r_alarm <= 1'b0;
            r_cause <= c_CAUSE_NONE;
            r_beats <= 8'd0;
        end else begin
            r_st    <= w_st_nxt;
            r_cnt   <= w_cnt_nxt;
            r_alarm <= w_alarm_nxt;
            r_cause <= w_cause_nxt;
            r_beats <= w_beats_nxt;
        end
    end

    always_comb begin
        w_st_nxt    = r_st;
        w_cnt_nxt   = r_cnt;
        w_alarm_nxt = r_alarm;
        w_cause_nxt = r_cause;
        w_beats_nxt = r_beats;

        case (r_st)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (bus.en) begin
                    w_st_nxt = S_ARM;
                end
            end

            S_ARM: begin
                if (!bus.en) begin
                    w_st_nxt  = S_IDLE;
                    w_cnt_nxt = '0;
                end else if (bus.pulse) begin
                    // First heartbeat only opens the window; no early check.
                    w_st_nxt    = S_RUN;
                    w_cnt_nxt   = '0;
                    w_beats_nxt = w_beats_inc;
                end else if (w_last) begin
                    w_st_nxt    = S_ALARM;
                    w_cnt_nxt   = '0;
                    w_alarm_nxt = 1'b1;
                    w_cause_nxt = c_CAUSE_TMO;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_RUN: begin
                if (!bus.en) begin
                    w_st_nxt  = S_IDLE;
                    w_cnt_nxt = '0;
                end else if (bus.pulse) begin
                    w_cnt_nxt = '0;
                    if (w_early) begin
                        w_st_nxt    = S_ALARM;
                        w_alarm_nxt = 1'b1;
                        w_cause_nxt = c_CAUSE_EARLY;
                    end else begin
                        w_beats_nxt = w_beats_inc;
                    end
                end else if (w_last) begin
                    w_st_nxt    = S_ALARM;
                    w_cnt_nxt   = '0;
                    w_alarm_nxt = 1'b1;
                    w_cause_nxt = c_CAUSE_TMO;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end

            S_ALARM: begin
                w_cnt_nxt = '0;
                if (bus.ack) begin
                    w_alarm_nxt = 1'b0;
                    w_cause_nxt = c_CAUSE_NONE;
                    w_beats_nxt = 8'd0;
                    w_st_nxt    = bus.en ? S_ARM : S_IDLE;
                end
            end

            default: begin
                w_st_nxt = S_IDLE;
            end
        endcase
    end

    assign bus.alarm = r_alarm;
    assign bus.cause = r_cause;
    assign bus.beats = r_beats;
    assign bus.st    = r_st;

endmodule
`default_nettype wire

// File: tb/tb_wdg_window_monitor.sv
`default_nettype none
// ============================================================================
// Module   : tb_wdg_window_monitor
// Brief    : Self-checking bench for wdg_window_monitor against a cycle-index
//            reference model (TIMEOUT=20, EARLY=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_wdg_window_monitor;

    localparam int c_T = 20;
    localparam int c_E = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   cyc;

    // Reference: 0 idle, 1 waiting for first beat, 2 running, 3 faulted.
    // m_ref is the cycle index of ARM entry or of the last accepted beat.
    int m_mode;
    int m_ref;
    int m_alarm;
    int m_cause;
    int m_beats;

    wdg_window_monitor_if bus ();

    wdg_window_monitor #(
        .TIMEOUT (c_T),
        .EARLY   (c_E),
        .CNT_W   (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_ref   = 0;
        m_alarm = 0;
        m_cause = 0;
        m_beats = 0;
    endtask

    task automatic model_step(input logic e, input logic p, input logic a);
        int g;
        g = cyc - m_ref;
        case (m_mode)
            0: if (e) begin m_mode = 1; m_ref = cyc + 1; end
            1: begin
                if (!e) m_mode = 0;
                else if (p) begin
                    m_mode  = 2;
                    m_ref   = cyc;
                    m_beats = (m_beats >= 255) ? 255 : m_beats + 1;
                end else if (g == c_T - 1) begin
                    m_mode = 3; m_alarm = 1; m_cause = 1;
                end
            end
            2: begin
                if (!e) m_mode = 0;
                else if (p) begin
                    if (c_E >= 2 && g < c_E) begin
                        m_mode = 3; m_alarm = 1; m_cause = 2;
                    end else begin
                        m_ref   = cyc;
                        m_beats = (m_beats >= 255) ? 255 : m_beats + 1;
                    end
                end else if (g == c_T) begin
                    m_mode = 3; m_alarm = 1; m_cause = 1;
                end
            end
            default: if (a) begin
                m_alarm = 0; m_cause = 0; m_beats = 0;
                if (e) begin m_mode = 1; m_ref = cyc + 1; end
                else m_mode = 0;
            end
        endcase
    endtask

    task automatic compare_all();
        check_eq("alarm", int'(bus.alarm), m_alarm);
        check_eq("cause", int'(bus.cause), m_cause);
        check_eq("beats", int'(bus.beats), m_beats);
        check_eq("st",    int'(bus.st),    m_mode);
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic tick(input logic e, input logic p, input logic a);
        bus.en    = e;
        bus.pulse = p;
        bus.ack   = a;
        @(posedge clk);
        model_step(e, p, a);
        cyc++;
        @(negedge clk);
        compare_all();
    endtask

    task automatic ticks(input int n, input logic e);
        for (int i = 0; i < n; i++) tick(e, 1'b0, 1'b0);
    endtask

    // Reset lands between clock edges, so outputs must clear with no edge.
    task automatic async_reset(input string tag);
        #2 rst = 1'b0;
        #1;
        check_eq({tag, "_alarm"}, int'(bus.alarm), 0);
        check_eq({tag, "_cause"}, int'(bus.cause), 0);
        check_eq({tag, "_beats"}, int'(bus.beats), 0);
        check_eq({tag, "_st"},    int'(bus.st),    0);
        model_reset();
        bus.en = 1'b0; bus.pulse = 1'b0; bus.ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int gap_left;
        logic e, p, a;
        n_chk = 0; n_err = 0; cyc = 0;
        rst = 1'b0;
        bus.en = 1'b0; bus.pulse = 1'b0; bus.ack = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check_eq("rst_alarm", int'(bus.alarm), 0);
        check_eq("rst_cause", int'(bus.cause), 0);
        check_eq("rst_beats", int'(bus.beats), 0);
        check_eq("rst_st",    int'(bus.st),    0);
        rst = 1'b1;
        ticks(3, 1'b0);
        check_eq("idle_hold", int'(bus.st), 0);

        // Steady heartbeat every 10 cycles, beats saturates.
        tick(1'b1, 1'b0, 1'b0);
        check_eq("en_to_arm", int'(bus.st), 1);
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b1, 1'b0);
            ticks(9, 1'b1);
        end
        check_eq("sat_beats", int'(bus.beats), 255);
        check_eq("sat_st",    int'(bus.st),    2);
        check_eq("sat_alarm", int'(bus.alarm), 0);

        // Gap of exactly TIMEOUT accepted, then a real timeout.
        tick(1'b1, 1'b1, 1'b0);
        ticks(19, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("gap20_alarm", int'(bus.alarm), 0);
        ticks(19, 1'b1);
        check_eq("pre_tmo_alarm", int'(bus.alarm), 0);
        tick(1'b1, 1'b0, 1'b0);
        check_eq("tmo_alarm", int'(bus.alarm), 1);
        check_eq("tmo_cause", int'(bus.cause), 1);

        // Alarm is sticky against pulses and enable drop.
        tick(1'b0, 1'b1, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("sticky_alarm", int'(bus.alarm), 1);
        check_eq("sticky_beats", int'(bus.beats), 255);
        tick(1'b1, 1'b0, 1'b1);
        check_eq("ack_alarm", int'(bus.alarm), 0);
        check_eq("ack_cause", int'(bus.cause), 0);
        check_eq("ack_beats", int'(bus.beats), 0);
        check_eq("ack_st",    int'(bus.st),    1);

        // ARM with no heartbeat times out TIMEOUT cycles after entry.
        ticks(19, 1'b1);
        check_eq("arm_pre_alarm", int'(bus.alarm), 0);
        tick(1'b1, 1'b0, 1'b0);
        check_eq("arm_tmo_alarm", int'(bus.alarm), 1);
        check_eq("arm_tmo_cause", int'(bus.cause), 1);
        tick(1'b1, 1'b0, 1'b1);

        // Gap 4 accepted, gap 3 is an early fault.
        tick(1'b1, 1'b1, 1'b0);
        ticks(3, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("gap4_alarm", int'(bus.alarm), 0);
        check_eq("gap4_beats", int'(bus.beats), 2);
        ticks(2, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        check_eq("early_alarm", int'(bus.alarm), 1);
        check_eq("early_cause", int'(bus.cause), 2);
        check_eq("early_beats", int'(bus.beats), 2);
        tick(1'b0, 1'b0, 1'b1);
        check_eq("ack_idle_st", int'(bus.st), 0);

        // Asynchronous reset in RUN and in ALARM.
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        ticks(2, 1'b1);
        async_reset("rst_run");
        ticks(4, 1'b0);
        check_eq("post_rst_idle", int'(bus.st), 0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        ticks(c_T + 1, 1'b1);
        check_eq("pre_rst_alarm", int'(bus.alarm), 1);
        async_reset("rst_alarm");
        ticks(3, 1'b0);
        check_eq("post_rst2_st", int'(bus.st), 0);

        // Randomized traffic against the reference model.
        gap_left = 0;
        for (int i = 0; i < 4000; i++) begin
            e = ($urandom_range(0, 99) < 97);
            a = ($urandom_range(0, 3) == 0);
            if (gap_left == 0) begin
                p = 1'b1;
                gap_left = $urandom_range(0, 23);
            end else begin
                p = 1'b0;
                gap_left--;
            end
            if ($urandom_range(0, 599) == 0) async_reset("rnd_rst");
            else tick(e, p, a);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
